// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//
// Instruction-fetch stage with a decoupled request/response instruction port
// and an in-order prefetch FIFO feeding the ID stage. Up to FIFO_DEPTH fetches
// are in flight or buffered at any time. A redirect (exception, eret or taken
// branch) retargets the fetch PC and marks every request still in flight as
// stale, so its response is dropped when it arrives. A taken branch keeps the
// FIFO head (the delay slot); exception and eret clear the whole FIFO.
//
// Ports
//   clock, reset                  rising-edge clock, async active-high reset
//   exception_valid               WB exception flush, jumps to EXC_VECTOR
//   eret_flush, eret_target       WB eret flush and CP0 EPC
//   branch_taken, branch_target   ID taken branch (only while head is valid)
//   id_allow_in                   ID accepts the FIFO head this cycle
//   if_to_id_valid/_pc/_inst      FIFO head towards ID
//   inst_req, inst_addr           memory request and address (fetch PC)
//   inst_addr_ok                  request accepted
//   inst_data_ok, inst_rdata      in-order response
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hbfc00000,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exception_valid,
    input  logic                  eret_flush,
    input  logic [ADDR_WIDTH-1:0] eret_target,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  id_allow_in,
    output logic                  if_to_id_valid,
    output logic [ADDR_WIDTH-1:0] if_to_id_pc,
    output logic [DATA_WIDTH-1:0] if_to_id_inst,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_addr_ok,
    input  logic                  inst_data_ok,
    input  logic [DATA_WIDTH-1:0] inst_rdata
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;

    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst [FIFO_DEPTH];

    logic                  redirect, hard_flush;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [CNT_W:0]        inflight;
    logic                  credit, issue, head_valid, pop, drop, push;

    assign hard_flush = exception_valid | eret_flush;
    assign redirect   = hard_flush | branch_taken;
    assign redirect_target = exception_valid ? EXC_VECTOR :
                             eret_flush      ? eret_target : branch_target;

    // A credit guarantees every issued request has a FIFO slot on return.
    assign inflight = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit   = inflight < DEPTH_EXT;
    assign inst_req = credit & ~redirect & ~reset;
    assign issue    = inst_req & inst_addr_ok;

    assign head_valid = count_q != '0;
    assign pop        = head_valid & id_allow_in;
    assign drop       = discard_q != '0;
    assign push       = inst_data_ok & ~drop & ~redirect;

    assign if_to_id_valid = head_valid;
    assign if_to_id_pc    = fifo_pc[rd_ptr_q];
    assign if_to_id_inst  = fifo_inst[rd_ptr_q];
    assign inst_addr      = fetch_pc_q;

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(inst_data_ok);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            // Every request still in flight after this cycle belongs to the
            // old path; already-stale ones are a subset of those.
            discard_d  = outstanding_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (inst_data_ok && drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
            end
        end

        if (hard_flush) begin
            count_d  = '0;
            wr_ptr_d = rd_ptr_q;
        end else if (branch_taken) begin
            // Keep only the delay slot, unless ID takes it this same cycle.
            if (head_valid && !pop) begin
                count_d  = CNT_W'(1);
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                count_d  = '0;
                rd_ptr_d = rd_ptr_q + PTR_W'(pop);
                wr_ptr_d = rd_ptr_q + PTR_W'(pop);
            end
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= resp_pc_q;
            fifo_inst[wr_ptr_q] <= inst_rdata;
        end
    end

endmodule
